// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared sizing constants and writeback bundle type for the register file
package reg_file_mp_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_AW    = $clog2(RF_NREGS);
  localparam int RF_NRD   = 2;
  localparam int RF_NWR   = 2;

  typedef struct packed {
    logic               en;
    logic [RF_AW-1:0]   addr;
    logic [RF_XLEN-1:0] data;
  } rf_wr_port_t;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// rtl/reg_file_mp_scoreboard.sv - per-register busy vector with alloc/clear priority and lookups
module reg_file_mp_scoreboard #(
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NREGS-1:0]       wr_hit_i,
  input  logic                   alloc_en_i,
  input  logic [AW-1:0]          alloc_addr_i,
  input  logic [NRD-1:0][AW-1:0] rd_addr_i,
  output logic                   alloc_ready_o,
  output logic [NRD-1:0]         rd_busy_o,
  output logic [NREGS-1:0]       busy_o
);

  logic [NREGS-1:0] busy_d;

  always_comb begin
    alloc_ready_o = (alloc_addr_i == '0) || !busy_o[alloc_addr_i] || wr_hit_i[alloc_addr_i];
  end

  // Clear on completed writes first, so a same-cycle allocation re-marks the register busy.
  always_comb begin
    busy_d = busy_o & ~wr_hit_i;
    if (alloc_en_i && alloc_ready_o && (alloc_addr_i != '0)) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o <= '0;
    end else begin
      busy_o <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_busy_o[i] = busy_o[rd_addr_i[i]] && !(BYPASS && wr_hit_i[rd_addr_i[i]]);
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with write bypass and busy scoreboard
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN   = RF_XLEN,
  parameter int NREGS  = RF_NREGS,
  parameter int NRD    = RF_NRD,
  parameter int NWR    = RF_NWR,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic                     alloc_en_i,
  input  logic [AW-1:0]            alloc_addr_i,
  output logic                     alloc_ready_o,
  output logic [NREGS-1:0]         busy_o
);

  localparam bit BYP = (BYPASS != 0);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           wr_hit;
  logic [NREGS-1:0][XLEN-1:0] wr_val;

  // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
  always_comb begin
    wr_hit = '0;
    wr_val = '0;
    for (int r = 1; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en_i[p] && (wr_addr_i[p] == AW'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data_i[p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_hit[r]) begin
          regs[r] <= wr_val[r];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      if (BYP && wr_hit[rd_addr_i[i]]) begin
        rd_data_o[i] = wr_val[rd_addr_i[i]];
      end else begin
        rd_data_o[i] = regs[rd_addr_i[i]];
      end
    end
  end

  reg_file_mp_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .AW     (AW),
    .BYPASS (BYP)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wr_hit_i      (wr_hit),
    .alloc_en_i    (alloc_en_i),
    .alloc_addr_i  (alloc_addr_i),
    .rd_addr_i     (rd_addr_i),
    .alloc_ready_o (alloc_ready_o),
    .rd_busy_o     (rd_busy_o),
    .busy_o        (busy_o)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed vector bench for reg_file_mp with bypass on and off
module tb_reg_file_mp;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0][4:0]  rd_addr;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic             alloc_en;
  logic [4:0]       alloc_addr;

  logic [1:0][31:0] rd_data_b, rd_data_n;
  logic [1:0]       rd_busy_b, rd_busy_n;
  logic             ready_b, ready_n;
  logic [31:0]      busy_b, busy_n;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_ready_o(ready_b), .busy_o(busy_b)
  );

  reg_file_mp #(.BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data_n), .rd_busy_o(rd_busy_n),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .alloc_en_i(alloc_en), .alloc_addr_i(alloc_addr),
    .alloc_ready_o(ready_n), .busy_o(busy_n)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        ae;
    logic [4:0]  aa;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [31:0] e_nb0;
    logic [1:0]  e_rb;
    logic [1:0]  e_rb_nb;
    logic        e_ready;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic ae, logic [4:0] aa,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] e_rd0,
                              logic [31:0] e_rd1, logic [31:0] e_nb0, logic [1:0] e_rb,
                              logic [1:0] e_rb_nb, logic e_ready, logic [31:0] e_busy);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ae = ae; v.aa = aa; v.ra0 = ra0; v.ra1 = ra1;
    v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_nb0 = e_nb0;
    v.e_rb = e_rb; v.e_rb_nb = e_rb_nb; v.e_ready = e_ready; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd31; alloc_addr = 5'd7;
    #1;
    chk("reset_rd0", rd_data_b[0], 32'h0);
    chk("reset_rd1", rd_data_b[1], 32'h0);
    chk("reset_busy", busy_b, 32'h0);
    chk("reset_ready", {31'b0, ready_b}, 32'h1);

    //        we     wa0  wd0            wa1  wd1        ae    aa     ra0    ra1    rd0            rd1            nb0            rb     rb_nb  rdy   busy
    vecs.push_back(mk(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b11, 5'd7, 32'h11,       5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7, 32'h22,       32'h22,       32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd7, 5'd5, 32'h22,       32'hDEADBEEF, 32'h22,       2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0,       32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd0, 5'd7, 32'h0,        32'h22,       32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd3, 5'd3, 5'd3, 32'h0,        32'h0,        32'h0,        2'b11, 2'b11, 1'b0, 32'h8));
    vecs.push_back(mk(2'b10, 5'd0, 32'h0,        5'd3, 32'h33, 1'b0, 5'd3, 5'd3, 5'd3, 32'h33,       32'h33,       32'h0,        2'b00, 2'b11, 1'b1, 32'h8));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd3, 5'd3, 5'd4, 32'h33,       32'h0,        32'h33,       2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 1'b1, 32'h0));
    vecs.push_back(mk(2'b01, 5'd9, 32'h99,       5'd0, 32'h0,  1'b1, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       32'h0,        2'b00, 2'b11, 1'b1, 32'h200));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       32'h99,       2'b11, 2'b11, 1'b0, 32'h200));
    vecs.push_back(mk(2'b11, 5'd5, 32'h55,       5'd6, 32'h66, 1'b0, 5'd0, 5'd5, 5'd6, 32'h55,       32'h66,       32'hDEADBEEF, 2'b00, 2'b00, 1'b1, 32'h200));
    vecs.push_back(mk(2'b00, 5'd0, 32'h0,        5'd0, 32'h0,  1'b0, 5'd0, 5'd6, 5'd5, 32'h66,       32'h55,       32'h66,       2'b00, 2'b00, 1'b1, 32'h200));

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      wr_en = vecs[k].we;
      wr_addr[0] = vecs[k].wa0; wr_data[0] = vecs[k].wd0;
      wr_addr[1] = vecs[k].wa1; wr_data[1] = vecs[k].wd1;
      alloc_en = vecs[k].ae; alloc_addr = vecs[k].aa;
      rd_addr[0] = vecs[k].ra0; rd_addr[1] = vecs[k].ra1;
      #1;
      chk($sformatf("v%0d_rd0", k), rd_data_b[0], vecs[k].e_rd0);
      chk($sformatf("v%0d_rd1", k), rd_data_b[1], vecs[k].e_rd1);
      chk($sformatf("v%0d_nb_rd0", k), rd_data_n[0], vecs[k].e_nb0);
      chk($sformatf("v%0d_rd_busy", k), {30'b0, rd_busy_b}, {30'b0, vecs[k].e_rb});
      chk($sformatf("v%0d_nb_rd_busy", k), {30'b0, rd_busy_n}, {30'b0, vecs[k].e_rb_nb});
      chk($sformatf("v%0d_ready", k), {31'b0, ready_b}, {31'b0, vecs[k].e_ready});
      chk($sformatf("v%0d_busy", k), busy_b, vecs[k].e_busy);
    end

    // Asynchronous reset between edges with a write in flight.
    @(negedge clk);
    drive_idle();
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h44;
    rd_addr[0] = 5'd9; rd_addr[1] = 5'd5;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rd0", rd_data_b[0], 32'h0);
    chk("async_rst_rd1", rd_data_b[1], 32'h0);
    chk("async_rst_busy", busy_b, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    rd_addr[0] = 5'd4;
    #1;
    chk("rst_discard_wr", rd_data_b[0], 32'h0);

    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr[0] = 5'(a); rd_addr[1] = 5'(31 - a); alloc_addr = 5'(a);
      #1;
      chk($sformatf("post_rst_rd0_x%0d", a), rd_data_b[0], 32'h0);
      chk($sformatf("post_rst_rd1_x%0d", 31 - a), rd_data_b[1], 32'h0);
      chk($sformatf("post_rst_rbusy_x%0d", a), {30'b0, rd_busy_b}, 32'h0);
      chk($sformatf("post_rst_ready_x%0d", a), {31'b0, ready_b}, 32'h1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
